// File: rtl/shift_operand_unit_if.sv
// rtl/shift_operand_unit_if.sv - request/response bundle for shift_operand_unit
//
// Groups the request handshake (in_valid/in_ready plus payload) and the
// result handshake (out_valid/out_ready plus result) of the shift unit.
//   slave  : the shift unit's view (takes requests, produces results)
//   master : the requester/consumer view
//
// Signals:
//   in_valid   request present
//   in_ready   request accepted when in_valid && in_ready at the clock edge
//   op         000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101 SEXT, 110 ZEXT, 111 PASS
//   amount     shift amount or field width, unsigned
//   operand    value to be shifted or extended
//   carry_in   current C flag
//   out_valid  result present
//   out_ready  consumer accepts result when out_valid && out_ready
//   out        result
//   carry_out  shifter carry
interface shift_operand_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [7:0]       amount;
  logic [WIDTH-1:0] operand;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;

  modport slave (
    input  in_valid, op, amount, operand, carry_in, out_ready,
    output in_ready, out_valid, out, carry_out
  );

  modport master (
    output in_valid, op, amount, operand, carry_in, out_ready,
    input  in_ready, out_valid, out, carry_out
  );
endinterface

// File: rtl/shift_operand_unit.sv
// rtl/shift_operand_unit.sv - two-stage barrel shifter / extender operand unit
//
// Two-stage pipeline: S1 registers the accepted request, S2 registers the
// computed result. The shift/extend datapath is combinational between the
// stages. Latency from acceptance to out_valid is two cycles; one result per
// cycle with out_ready held high.
//
// Parameters:
//   WIDTH  datapath width, power of two, 8..64
//   LOG_W  width of the rotate index, $clog2(WIDTH)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; empties the pipeline and zeroes
//          every register
//   flush  synchronous; empties both stages on the next edge and blocks
//          acceptance while high
//   bus    request/result handshake bundle (slave modport)
module shift_operand_unit #(
  parameter int WIDTH = 32,
  parameter int LOG_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  shift_operand_unit_if.slave bus
);

  localparam logic [2:0] OP_LSL  = 3'b000;
  localparam logic [2:0] OP_LSR  = 3'b001;
  localparam logic [2:0] OP_ASR  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_RRX  = 3'b100;
  localparam logic [2:0] OP_SEXT = 3'b101;
  localparam logic [2:0] OP_ZEXT = 3'b110;

  // WIDTH expressed at the width of a zero-extended amount for comparisons.
  localparam logic [8:0] WIDTH_AMT = 9'(WIDTH);

  // S1: registered request
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [7:0]       s1_amount;
  logic [WIDTH-1:0] s1_operand;
  logic             s1_carry;

  // S2: registered result
  logic             s2_valid;
  logic [WIDTH-1:0] s2_out;
  logic             s2_carry;

  // Handshake / advance control
  logic s2_adv;
  logic s1_adv;
  logic accept;
  logic s2_load;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign s2_load      = s2_adv && s1_valid && !flush;

  assign bus.out_valid = s2_valid;
  assign bus.out       = s2_out;
  assign bus.carry_out = s2_carry;

  // Datapath. Every shift is done on a value one bit wider than the operand
  // so the carry falls out of the extra bit; shifting by an amount larger
  // than the vector yields zeros (or sign copies), which covers all the
  // out-of-range amount cases without ever indexing outside the operand.
  logic                    amt_zero;
  logic                    field_ok;
  logic [LOG_W-1:0]        rot_amt;
  logic [WIDTH:0]          lsl_ext;
  logic [WIDTH:0]          lsr_ext;
  logic signed [WIDTH:0]   asr_src;
  logic signed [WIDTH:0]   asr_ext;
  logic [2*WIDTH-1:0]      ror_ext;
  logic [WIDTH-1:0]        field_mask;
  logic [WIDTH-1:0]        field_probe;
  logic                    field_sign;
  logic [WIDTH-1:0]        sext_val;
  logic [WIDTH-1:0]        zext_val;
  logic [WIDTH-1:0]        res_out;
  logic                    res_carry;

  assign amt_zero = (s1_amount == 8'd0);
  assign field_ok = !amt_zero && ({1'b0, s1_amount} < WIDTH_AMT);

  // Carry of LSL is the last bit shifted out at the top: bit WIDTH of the
  // widened result (operand[WIDTH-n], operand[0] for n == WIDTH, 0 beyond).
  assign lsl_ext = {1'b0, s1_operand} << s1_amount;

  // Carry of LSR/ASR is the last bit shifted out at the bottom, caught in
  // the guard bit appended below the LSB.
  assign lsr_ext = {s1_operand, 1'b0} >> s1_amount;
  assign asr_src = {s1_operand, 1'b0};
  assign asr_ext = asr_src >>> s1_amount;

  // Rotate by amount mod WIDTH (WIDTH is a power of two). The carry is the
  // result MSB, which is operand[r-1], or operand[WIDTH-1] when r == 0.
  assign rot_amt = s1_amount[LOG_W-1:0];
  assign ror_ext = {s1_operand, s1_operand} >> rot_amt;

  // Field of n low bits. For n == 0 the probe shift underflows to 255 and
  // returns zero; the field result is not used then anyway.
  assign field_mask  = ~({WIDTH{1'b1}} << s1_amount);
  assign field_probe = s1_operand >> (s1_amount - 8'd1);
  assign field_sign  = field_probe[0];
  assign sext_val    = field_sign ? (s1_operand | ~field_mask) : (s1_operand & field_mask);
  assign zext_val    = s1_operand & field_mask;

  always_comb begin
    res_out   = s1_operand;
    res_carry = s1_carry;
    case (s1_op)
      OP_LSL: begin
        if (!amt_zero) begin
          res_out   = lsl_ext[WIDTH-1:0];
          res_carry = lsl_ext[WIDTH];
        end
      end
      OP_LSR: begin
        if (!amt_zero) begin
          res_out   = lsr_ext[WIDTH:1];
          res_carry = lsr_ext[0];
        end
      end
      OP_ASR: begin
        if (!amt_zero) begin
          res_out   = asr_ext[WIDTH:1];
          res_carry = asr_ext[0];
        end
      end
      OP_ROR: begin
        if (!amt_zero) begin
          res_out   = ror_ext[WIDTH-1:0];
          res_carry = ror_ext[WIDTH-1];
        end
      end
      OP_RRX: begin
        res_out   = {s1_carry, s1_operand[WIDTH-1:1]};
        res_carry = s1_operand[0];
      end
      OP_SEXT: begin
        if (field_ok) res_out = sext_val;
      end
      OP_ZEXT: begin
        if (field_ok) res_out = zext_val;
      end
      default: begin
        res_out   = s1_operand;
        res_carry = s1_carry;
      end
    endcase
  end

  // S1 register: request data loads only on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_op      <= 3'b000;
      s1_amount  <= 8'd0;
      s1_operand <= '0;
      s1_carry   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= bus.in_valid;
      end
      if (accept) begin
        s1_op      <= bus.op;
        s1_amount  <= bus.amount;
        s1_operand <= bus.operand;
        s1_carry   <= bus.carry_in;
      end
    end
  end

  // S2 register: result loads only when a valid S1 entry moves forward, so
  // the output holds stable while stalled or idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_carry <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_load) begin
        s2_out   <= res_out;
        s2_carry <= res_carry;
      end
    end
  end

endmodule

// File: tb/tb_shift_operand_unit.sv
// tb/tb_shift_operand_unit.sv - self-checking bench for shift_operand_unit
module tb_shift_operand_unit;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic flush_wide;
  int checks = 0;
  int errors = 0;

  // Expected entries: [64] carry, [63:0] result (low WIDTH bits used)
  logic [64:0] q32[$];
  logic [64:0] q16[$];
  logic [64:0] q64[$];

  always #5 clk = ~clk;

  shift_operand_unit_if #(.WIDTH(32)) if32 ();
  shift_operand_unit_if #(.WIDTH(16)) if16 ();
  shift_operand_unit_if #(.WIDTH(64)) if64 ();

  shift_operand_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(if32));
  shift_operand_unit #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .flush(flush_wide), .bus(if16));
  shift_operand_unit #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .flush(flush_wide), .bus(if64));

  // Bit-by-bit reference model for width w (operand already truncated to w).
  function automatic logic [64:0] ref_shift(input int w, input logic [2:0] op,
                                            input logic [7:0] n, input logic [63:0] x,
                                            input logic cin);
    logic [63:0] r;
    logic        c;
    int          k;
    int          s;
    r = '0;
    c = cin;
    k = int'(n);
    s = k % w;
    case (op)
      3'd0: begin
        if (k == 0) r = x;
        else if (k < w) begin
          for (int i = k; i < w; i++) r[i] = x[i-k];
          c = x[w-k];
        end else if (k == w) c = x[0];
        else c = 1'b0;
      end
      3'd1: begin
        if (k == 0) r = x;
        else if (k < w) begin
          for (int i = 0; i < w - k; i++) r[i] = x[i+k];
          c = x[k-1];
        end else if (k == w) c = x[w-1];
        else c = 1'b0;
      end
      3'd2: begin
        if (k == 0) r = x;
        else begin
          for (int i = 0; i < w; i++) r[i] = (i + k < w) ? x[i+k] : x[w-1];
          c = (k < w) ? x[k-1] : x[w-1];
        end
      end
      3'd3: begin
        if (k == 0) r = x;
        else begin
          for (int i = 0; i < w; i++) r[i] = x[(i+s)%w];
          c = (s == 0) ? x[w-1] : x[s-1];
        end
      end
      3'd4: begin
        for (int i = 0; i < w - 1; i++) r[i] = x[i+1];
        r[w-1] = cin;
        c = x[0];
      end
      3'd5, 3'd6: begin
        if (k >= 1 && k < w) begin
          for (int i = 0; i < w; i++) r[i] = (i < k) ? x[i] : ((op == 3'd5) ? x[k-1] : 1'b0);
        end else r = x;
      end
      default: r = x;
    endcase
    return {c, r};
  endfunction

  // Present one request on the 32-bit unit (call at posedge+1). Leaves
  // in_valid high so consecutive calls are back-to-back.
  task automatic send32(input logic [2:0] op, input logic [7:0] amt, input logic [31:0] x,
                        input logic cin, input logic [64:0] e);
    int waited = 0;
    if32.in_valid = 1'b1;
    if32.op       = op;
    if32.amount   = amt;
    if32.operand  = x;
    if32.carry_in = cin;
    @(negedge clk);
    while (!if32.in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!if32.in_ready) begin
      errors++;
      $display("FAIL send32_accept in_ready=%b required 1", if32.in_ready);
    end else begin
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (if32.out_valid !== 1'b0 || if32.out !== 32'h0 || if32.carry_out !== 1'b0 || if32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state out_valid=%b out=%h carry=%b in_ready=%b required 0 0 0 1",
               if32.out_valid, if32.out, if32.carry_out, if32.in_ready);
    end
    if32.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if32.out_valid !== 1'b0 || if64.out_valid !== 1'b0 || if16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold out_valid32=%b out_valid16=%b out_valid64=%b required 0",
               if32.out_valid, if16.out_valid, if64.out_valid);
    end
    @(negedge clk);
    if32.in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_latency();
    logic [64:0] e;
    @(posedge clk);
    #1;
    if32.out_ready = 1'b1;
    if32.in_valid  = 1'b1;
    if32.op        = 3'd0;
    if32.amount    = 8'd1;
    if32.operand   = 32'h8000_0001;
    if32.carry_in  = 1'b0;
    @(negedge clk);
    if (if32.in_ready) q32.push_back({1'b1, 64'h2});
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early out_valid=%b required 0", if32.out_valid);
    end
    @(negedge clk);
    checks++;
    if (if32.out_valid !== 1'b1 || q32.size() == 0) begin
      errors++;
      $display("FAIL latency_two out_valid=%b queued=%0d required 1 1", if32.out_valid, q32.size());
    end else begin
      e = q32.pop_front();
      checks++;
      if (if32.out !== e[31:0] || if32.carry_out !== e[64]) begin
        errors++;
        $display("FAIL latency_value out=%h carry=%b required out=%h carry=%b",
                 if32.out, if32.carry_out, e[31:0], e[64]);
      end
    end
  endtask

  task automatic test_vectors();
    logic [2:0]  v_op [16] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4,
                               3'd5, 3'd6, 3'd0, 3'd7, 3'd1, 3'd2, 3'd5, 3'd6};
    logic [7:0]  v_n  [16] = '{8'd1, 8'd32, 8'd33, 8'd32, 8'd40, 8'd4, 8'd64, 8'd7,
                               8'd8, 8'd12, 8'd0, 8'd200, 8'd31, 8'd31, 8'd0, 8'd32};
    logic [31:0] v_x  [16] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0000,
                               32'h8000_0000, 32'h0000_00F1, 32'h0000_00F1, 32'h0000_0003,
                               32'h0000_0080, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_BEEF,
                               32'h8000_0000, 32'h4000_0000, 32'h1234_5678, 32'hFFFF_0000};
    logic        v_c  [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] v_eo [16] = '{32'h0000_0002, 32'h0, 32'h0, 32'h0,
                               32'hFFFF_FFFF, 32'h1000_000F, 32'h0000_00F1, 32'h8000_0001,
                               32'hFFFF_FF80, 32'h0000_0FFF, 32'h1234_5678, 32'h0000_BEEF,
                               32'h0000_0001, 32'h0, 32'h1234_5678, 32'hFFFF_0000};
    logic        v_ec [16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [64:0] e;
    @(posedge clk);
    #1;
    if32.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) send32(v_op[i], v_n[i], v_x[i], v_c[i], {v_ec[i], 32'h0, v_eo[i]});
        if32.in_valid = 1'b0;
      end
      begin
        int got = 0;
        for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
          @(negedge clk);
          if (if32.out_valid && if32.out_ready) begin
            checks++;
            if (q32.size() == 0) begin
              errors++;
              $display("FAIL vectors_extra out=%h required no result", if32.out);
            end else begin
              e = q32.pop_front();
              if (if32.out !== e[31:0] || if32.carry_out !== e[64]) begin
                errors++;
                $display("FAIL vectors_%0d out=%h carry=%b required out=%h carry=%b",
                         got, if32.out, if32.carry_out, e[31:0], e[64]);
              end
            end
            got++;
          end
        end
        checks++;
        if (got != 16) begin
          errors++;
          $display("FAIL vectors_count got=%0d required 16", got);
        end
      end
    join
  endtask

  task automatic test_back_to_back();
    logic [64:0] e;
    int first_cyc = -1;
    int last_cyc = -1;
    @(posedge clk);
    #1;
    if32.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [2:0]  op  = 3'($urandom_range(0, 7));
          logic [7:0]  n   = 8'($urandom_range(0, 40));
          logic [31:0] x   = $urandom;
          logic        cin = 1'($urandom);
          send32(op, n, x, cin, ref_shift(32, op, n, {32'h0, x}, cin));
        end
        if32.in_valid = 1'b0;
      end
      begin
        int got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
          @(negedge clk);
          if (if32.out_valid && if32.out_ready) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            checks++;
            if (q32.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra out=%h required no result", if32.out);
            end else begin
              e = q32.pop_front();
              if (if32.out !== e[31:0] || if32.carry_out !== e[64]) begin
                errors++;
                $display("FAIL b2b_%0d out=%h carry=%b required out=%h carry=%b",
                         got, if32.out, if32.carry_out, e[31:0], e[64]);
              end
            end
            got++;
          end
        end
        checks++;
        if (got != 8 || last_cyc - first_cyc != 7) begin
          errors++;
          $display("FAIL b2b_spacing got=%0d span=%0d required 8 7", got, last_cyc - first_cyc);
        end
      end
    join
  endtask

  task automatic test_stall();
    logic [64:0] hold;
    logic [64:0] e;
    int got = 0;
    @(posedge clk);
    #1;
    if32.out_ready = 1'b0;
    send32(3'd3, 8'd1, 32'h0000_00F1, 1'b0, {1'b1, 32'h0, 32'h8000_0078});
    send32(3'd1, 8'd4, 32'hF000_0000, 1'b1, {1'b0, 32'h0, 32'h0F00_0000});
    if32.in_valid = 1'b0;
    hold = q32[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1 ||
          if32.out !== hold[31:0] || if32.carry_out !== hold[64]) begin
        errors++;
        $display("FAIL stall_%0d in_ready=%b out_valid=%b out=%h carry=%b required 0 1 %h %b",
                 i, if32.in_ready, if32.out_valid, if32.out, if32.carry_out, hold[31:0], hold[64]);
      end
    end
    @(posedge clk);
    #1;
    if32.out_ready = 1'b1;
    for (int cyc = 0; cyc < 8 && got < 2; cyc++) begin
      @(negedge clk);
      if (if32.out_valid) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL stall_extra out=%h required no result", if32.out);
        end else begin
          e = q32.pop_front();
          if (if32.out !== e[31:0] || if32.carry_out !== e[64]) begin
            errors++;
            $display("FAIL stall_drain_%0d out=%h carry=%b required out=%h carry=%b",
                     got, if32.out, if32.carry_out, e[31:0], e[64]);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != 2 || q32.size() != 0) begin
      errors++;
      $display("FAIL stall_count got=%0d left=%0d required 2 0", got, q32.size());
    end
  endtask

  task automatic test_flush();
    logic [64:0] e;
    int got = 0;
    @(posedge clk);
    #1;
    if32.out_ready = 1'b0;
    send32(3'd7, 8'd0, 32'hAAAA_5555, 1'b1, {1'b1, 32'h0, 32'hAAAA_5555});
    send32(3'd7, 8'd0, 32'h5555_AAAA, 1'b0, {1'b0, 32'h0, 32'h5555_AAAA});
    flush = 1'b1;
    if32.operand = 32'hDEAD_0000;
    @(negedge clk);
    checks++;
    if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_block in_ready=%b out_valid=%b required 0 1", if32.in_ready, if32.out_valid);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    if32.in_valid = 1'b0;
    q32.delete();
    if32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (if32.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_stale_%0d out_valid=%b out=%h required 0", i, if32.out_valid, if32.out);
      end
    end
    @(posedge clk);
    #1;
    send32(3'd5, 8'd16, 32'h0000_7FFF, 1'b1, {1'b1, 32'h0, 32'h0000_7FFF});
    if32.in_valid = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (if32.out_valid) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL flush_extra out=%h required no result", if32.out);
        end else begin
          e = q32.pop_front();
          if (if32.out !== e[31:0] || if32.carry_out !== e[64]) begin
            errors++;
            $display("FAIL flush_after out=%h carry=%b required out=%h carry=%b",
                     if32.out, if32.carry_out, e[31:0], e[64]);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != 1) begin
      errors++;
      $display("FAIL flush_after_count got=%0d required 1", got);
    end
  endtask

  task automatic test_async_reset();
    logic [64:0] e;
    @(posedge clk);
    #1;
    if32.out_ready = 1'b0;
    send32(3'd7, 8'd0, 32'hDEAD_BEEF, 1'b1, {1'b1, 32'h0, 32'hDEAD_BEEF});
    send32(3'd0, 8'd31, 32'h0000_0001, 1'b0, {1'b0, 32'h0, 32'h8000_0000});
    if32.in_valid = 1'b0;
    checks++;
    if (if32.out_valid !== 1'b1 || if32.out !== 32'hDEAD_BEEF || if32.carry_out !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre out_valid=%b out=%h carry=%b required 1 deadbeef 1",
               if32.out_valid, if32.out, if32.carry_out);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (if32.out_valid !== 1'b0 || if32.out !== 32'h0 || if32.carry_out !== 1'b0 || if32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_now out_valid=%b out=%h carry=%b in_ready=%b required 0 0 0 1",
               if32.out_valid, if32.out, if32.carry_out, if32.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    q32.delete();
    if32.out_ready = 1'b1;
    if32.in_valid  = 1'b1;
    if32.op        = 3'd6;
    if32.amount    = 8'd8;
    if32.operand   = 32'h0000_ABCD;
    if32.carry_in  = 1'b1;
    #1;
    checks++;
    if (if32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_ready in_ready=%b required 1", if32.in_ready);
    end else begin
      q32.push_back({1'b1, 32'h0, 32'h0000_00CD});
    end
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_early out_valid=%b out=%h required 0", if32.out_valid, if32.out);
    end
    @(negedge clk);
    checks++;
    if (if32.out_valid !== 1'b1 || q32.size() == 0) begin
      errors++;
      $display("FAIL areset_first out_valid=%b queued=%0d required 1 1", if32.out_valid, q32.size());
    end else begin
      e = q32.pop_front();
      if (if32.out !== e[31:0] || if32.carry_out !== e[64]) begin
        errors++;
        $display("FAIL areset_value out=%h carry=%b required out=%h carry=%b",
                 if32.out, if32.carry_out, e[31:0], e[64]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if32.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL areset_stale_%0d out_valid=%b out=%h required 0", i, if32.out_valid, if32.out);
      end
    end
  endtask

  task automatic test_widths();
    int          am16 [6] = '{0, 1, 15, 16, 17, 255};
    int          am64 [6] = '{0, 1, 63, 64, 65, 255};
    logic [64:0] e16;
    logic [64:0] e64;
    logic [64:0] p;
    logic [2:0]  op;
    logic [15:0] x16;
    logic [63:0] x64;
    logic        cin;
    @(posedge clk);
    #1;
    if16.out_ready = 1'b1;
    if64.out_ready = 1'b1;
    for (int cyc = 0; cyc < 102; cyc++) begin
      if (cyc < 96) begin
        op  = 3'(cyc / 12);
        cin = 1'($urandom);
        x16 = 16'($urandom);
        x64 = {$urandom, $urandom};
        if (cyc % 2 == 0) begin
          x16[15] = 1'b1;
          x64[63] = 1'b1;
        end else begin
          x16[15] = 1'b0;
          x64[63] = 1'b0;
        end
        if16.in_valid = 1'b1;
        if16.op       = op;
        if16.amount   = 8'(am16[(cyc/2)%6]);
        if16.operand  = x16;
        if16.carry_in = cin;
        if64.in_valid = 1'b1;
        if64.op       = op;
        if64.amount   = 8'(am64[(cyc/2)%6]);
        if64.operand  = x64;
        if64.carry_in = cin;
        e16 = ref_shift(16, op, 8'(am16[(cyc/2)%6]), {48'h0, x16}, cin);
        e64 = ref_shift(64, op, 8'(am64[(cyc/2)%6]), x64, cin);
      end else begin
        if16.in_valid = 1'b0;
        if64.in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc < 96 && if16.in_ready) q16.push_back(e16);
      if (cyc < 96 && if64.in_ready) q64.push_back(e64);
      if (if16.out_valid) begin
        checks++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL w16_extra out=%h required no result", if16.out);
        end else begin
          p = q16.pop_front();
          if (if16.out !== p[15:0] || if16.carry_out !== p[64]) begin
            errors++;
            $display("FAIL w16_cyc%0d out=%h carry=%b required out=%h carry=%b",
                     cyc, if16.out, if16.carry_out, p[15:0], p[64]);
          end
        end
      end
      if (if64.out_valid) begin
        checks++;
        if (q64.size() == 0) begin
          errors++;
          $display("FAIL w64_extra out=%h required no result", if64.out);
        end else begin
          p = q64.pop_front();
          if (if64.out !== p[63:0] || if64.carry_out !== p[64]) begin
            errors++;
            $display("FAIL w64_cyc%0d out=%h carry=%b required out=%h carry=%b",
                     cyc, if64.out, if64.carry_out, p[63:0], p[64]);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (q16.size() != 0 || q64.size() != 0) begin
      errors++;
      $display("FAIL widths_drain left16=%0d left64=%0d required 0 0", q16.size(), q64.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    flush_wide = 1'b0;
    if32.in_valid = 1'b0; if32.op = 3'd0; if32.amount = 8'd0; if32.operand = '0;
    if32.carry_in = 1'b0; if32.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.op = 3'd0; if16.amount = 8'd0; if16.operand = '0;
    if16.carry_in = 1'b0; if16.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.op = 3'd0; if64.amount = 8'd0; if64.operand = '0;
    if64.carry_in = 1'b0; if64.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_widths();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
